aes256_gcm_top: RTL and testbench
=================================

Name: aes256_gcm_top

Overview:
- Fixed-geometry AES-256-GCM authenticated encryptor for one MACsec-style packet: 28-byte AAD and 48-byte (3-block) plaintext.
- Produces 3 ciphertext blocks and a 128-bit tag.
- Single iterative AES-256 round datapath plus a single-cycle GF(2^128) multiplier.
- Used as the top-level crypto engine; software-visible results are held until the next start.

Parameters:
- None. Block geometry is fixed: AAD = 224 bits, plaintext = 384 bits, nonce = 96 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- key  input  256  AES-256 key; key[255:248] is key byte 0
- nonce  input  96  IV; J0 = {nonce, 32'h00000001}
- plaintext1  input  128  plaintext block 1; bit 127 is byte 0
- plaintext2  input  128  plaintext block 2
- plaintext3  input  128  plaintext block 3
- aad  input  224  additional authenticated data; aad[223:216] is byte 0
- ciphertext1  output  128  ciphertext block 1
- ciphertext2  output  128  ciphertext block 2
- ciphertext3  output  128  ciphertext block 3
- tag  output  128  GCM authentication tag, full 128 bits
- done  output  1  result-valid level

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: FSM goes to IDLE; all outputs, including done, are 0. Reset mid-operation aborts the operation; no partial result is kept.
- IDLE with start=1: register key, nonce, plaintexts and aad; clear done; go to AES. Inputs may change after this edge.
- start while busy is ignored.
- Conventions: big-endian byte order throughout; GCM bit-reflected field, multiplication by x uses R = 0xE1 || 0^120.
- AES state, per 128-bit block, 15 cycles:
  - load cycle: state = in ^ rk0;
  - 13 full rounds;
  - final round without MixColumns.
  - Round keys come from an on-the-fly forward AES-256 key schedule restarted for each block; standard Rcon, with SubWord-only on odd 128-bit steps.
- Block order:
  - H = E(K, 0^128)
  - S = E(K, J0)
  - Ki = E(K, {nonce, i+1}) for i = 1..3
  - ciphertext_i = plaintext_i ^ Ki
- GHASH state: 6 cycles, one multiply each, X = (X ^ B) * H starting from X = 0, with these blocks in order:
  - aad[223:96]
  - {aad[95:0], 32'h0}
  - C1, C2, C3
  - {64'd224, 64'd384}
- FINAL state: tag = X ^ S; ciphertext/tag registers updated; done = 1; return to IDLE.
- Latency: done visible 82 rising edges after the edge that sampled start (75 AES + 6 GHASH + 1 FINAL).
- done and all result outputs hold until the next accepted start or reset. start in the done state (IDLE) is accepted normally and clears done on the next edge.

Optional Feature:
- Macro AES_GCM_DECRYPT_EN.
- When defined:
  - adds input port decrypt (1 bit), sampled with start;
  - decrypt=1: plaintextN ports carry ciphertext, ciphertextN outputs carry recovered plaintext (same XOR), and GHASH consumes the input blocks rather than the outputs;
  - tag is the expected tag. The design does no compare; software compares.
- When undefined: no decrypt port; encrypt only, exactly as above.

Test Plan:
- MACsec 2.2.2 vector. Inputs:
  - key E3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72
  - nonce 12153524C0895E81B2C28465
  - aad D609B1F056637A0D46DF998D88E52E00B2C2846512153524C0895E81
  - pt1 08000F101112131415161718191A1B1C, pt2 1D1E1F202122232425262728292A2B2C, pt3 2D2E2F303132333435363738393A0002
  - Required: ct1 e2006eb42f5277022d9b19925bc419d7, ct2 a592666c925fe2ef718eb4e308efeaa7, ct3 c5273b394118860a5be2a97f56ab7836, tag 5ca597cdbb3edb8d1a1151ea0af7b436, done after exactly 82 edges.
- Zero key, zero nonce, zero plaintext -> ct1 = cea7403d4d606b6e074ec5d3baf39d18.
- Reset state, and reset asserted 40 cycles into the 2.2.2 run:
  - while rst: outputs/done 0;
  - after release: no done;
  - a fresh start then gives the 2.2.2 results.
- Repulse start at cycle 30 of a run, and change inputs after start -> ignored; same 2.2.2 results at edge 82.
- Hold: after done, 100 idle cycles -> done stays 1 and outputs stable. Second start -> done drops next edge and reasserts 82 edges later.
- With AES_GCM_DECRYPT_EN, decrypt=1, feed 2.2.2 ciphertext -> outputs are the 2.2.2 plaintext; tag = 5ca597cdbb3edb8d1a1151ea0af7b436.

Source files
------------

// File: rtl/aes256_gcm_top.sv
// AES-256-GCM encryptor for one fixed-geometry packet (28-byte AAD, 3 data blocks).
// Define AES_GCM_DECRYPT_EN to add the decrypt input (GHASH over the input blocks).
module aes256_gcm_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef AES_GCM_DECRYPT_EN
    input  logic         decrypt,
`endif
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [127:0] plaintext1,
    input  logic [127:0] plaintext2,
    input  logic [127:0] plaintext3,
    input  logic [223:0] aad,
    output logic [127:0] ciphertext1,
    output logic [127:0] ciphertext2,
    output logic [127:0] ciphertext3,
    output logic [127:0] tag,
    output logic         done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AES   = 2'd1;
    localparam logic [1:0] ST_GHASH = 2'd2;
    localparam logic [1:0] ST_FINAL = 2'd3;

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 followed by the affine map; flattens to an 8-input lookup.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] b;
        sq = x;
        b  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf8_mul(sq, sq);
            b  = gf8_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // GCM bit-reflected field: bit 127 is the x^0 coefficient.
    function automatic logic [127:0] gf128_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [2:0]   blk_q, blk_d;
    logic [2:0]   ghs_q, ghs_d;
    logic [255:0] key_q, key_d;
    logic [95:0]  nonce_q, nonce_d;
    logic [127:0] pt_q [3];
    logic [127:0] pt_d [3];
    logic [223:0] aad_q, aad_d;
    logic [127:0] aes_q, aes_d;
    logic [255:0] kwin_q, kwin_d;
    logic [127:0] h_q, h_d;
    logic [127:0] s_q, s_d;
    logic [127:0] c_q [3];
    logic [127:0] c_d [3];
    logic [127:0] x_q, x_d;
    logic [127:0] ct_q [3];
    logic [127:0] ct_d [3];
    logic [127:0] tag_q, tag_d;
    logic         done_q, done_d;
    logic         dec_w;

`ifdef AES_GCM_DECRYPT_EN
    logic dec_q, dec_d;

    always_comb begin
        dec_d = dec_q;
        if (fsm_q == ST_IDLE && start) dec_d = decrypt;
    end

    always_ff @(posedge clk) begin
        if (rst) dec_q <= 1'b0;
        else     dec_q <= dec_d;
    end

    assign dec_w = dec_q;
`else
    assign dec_w = 1'b0;
`endif

    // kwin_q holds {rk(r-1), rk(r)}; odd rounds derive an even round key (RotWord + Rcon).
    logic [31:0]  ks_in, ks_sub, ks_t;
    logic [7:0]   rcon;
    logic [127:0] next_rk;
    logic [127:0] sub_state, round_out, final_out, aes_in, gh_blk, gf_prod;

    assign ks_in = rnd_q[0] ? {kwin_q[23:0], kwin_q[31:24]} : kwin_q[31:0];
    assign rcon  = rnd_q[0] ? (8'h01 << rnd_q[3:1]) : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ks_sbox
            assign ks_sub[8*gi +: 8] = sbox(ks_in[8*gi +: 8]);
        end
        for (gi = 0; gi < 16; gi++) begin : g_st_sbox
            assign sub_state[8*gi +: 8] = sbox(aes_q[8*gi +: 8]);
        end
    endgenerate

    assign ks_t = ks_sub ^ {rcon, 24'h0};
    always_comb begin
        next_rk[127:96] = kwin_q[255:224] ^ ks_t;
        next_rk[95:64]  = kwin_q[223:192] ^ next_rk[127:96];
        next_rk[63:32]  = kwin_q[191:160] ^ next_rk[95:64];
        next_rk[31:0]   = kwin_q[159:128] ^ next_rk[63:32];
    end

    assign round_out = mix_columns(shift_rows(sub_state)) ^ kwin_q[127:0];
    assign final_out = shift_rows(sub_state) ^ kwin_q[127:0];
    // Block 0 is H = E(K,0); block n>0 encrypts counter n (1 = J0).
    assign aes_in    = (blk_q == 3'd0) ? 128'h0 : {nonce_q, 29'h0, blk_q};

    always_comb begin
        case (ghs_q)
            3'd0:    gh_blk = aad_q[223:96];
            3'd1:    gh_blk = {aad_q[95:0], 32'h0};
            3'd2:    gh_blk = dec_w ? pt_q[0] : c_q[0];
            3'd3:    gh_blk = dec_w ? pt_q[1] : c_q[1];
            3'd4:    gh_blk = dec_w ? pt_q[2] : c_q[2];
            default: gh_blk = {64'd224, 64'd384};
        endcase
    end

    assign gf_prod = gf128_mul(x_q ^ gh_blk, h_q);

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        ghs_d   = ghs_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        pt_d    = pt_q;
        aad_d   = aad_q;
        aes_d   = aes_q;
        kwin_d  = kwin_q;
        h_d     = h_q;
        s_d     = s_q;
        c_d     = c_q;
        x_d     = x_q;
        ct_d    = ct_q;
        tag_d   = tag_q;
        done_d  = done_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    nonce_d = nonce;
                    pt_d[0] = plaintext1;
                    pt_d[1] = plaintext2;
                    pt_d[2] = plaintext3;
                    aad_d   = aad;
                    done_d  = 1'b0;
                    rnd_d   = 4'd0;
                    blk_d   = 3'd0;
                    ghs_d   = 3'd0;
                    x_d     = '0;
                    fsm_d   = ST_AES;
                end
            end
            ST_AES: begin
                if (rnd_q == 4'd0) begin
                    aes_d  = aes_in ^ key_q[255:128];
                    kwin_d = key_q;
                    rnd_d  = 4'd1;
                end else if (rnd_q != 4'd14) begin
                    aes_d  = round_out;
                    kwin_d = {kwin_q[127:0], next_rk};
                    rnd_d  = rnd_q + 4'd1;
                end else begin
                    case (blk_q)
                        3'd0:    h_d    = final_out;
                        3'd1:    s_d    = final_out;
                        3'd2:    c_d[0] = pt_q[0] ^ final_out;
                        3'd3:    c_d[1] = pt_q[1] ^ final_out;
                        default: c_d[2] = pt_q[2] ^ final_out;
                    endcase
                    rnd_d = 4'd0;
                    if (blk_q == 3'd4) fsm_d = ST_GHASH;
                    else               blk_d = blk_q + 3'd1;
                end
            end
            ST_GHASH: begin
                x_d = gf_prod;
                if (ghs_q == 3'd5) fsm_d = ST_FINAL;
                else               ghs_d = ghs_q + 3'd1;
            end
            default: begin
                tag_d  = x_q ^ s_q;
                ct_d   = c_q;
                done_d = 1'b1;
                fsm_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            ghs_q   <= '0;
            key_q   <= '0;
            nonce_q <= '0;
            pt_q    <= '{default: '0};
            aad_q   <= '0;
            aes_q   <= '0;
            kwin_q  <= '0;
            h_q     <= '0;
            s_q     <= '0;
            c_q     <= '{default: '0};
            x_q     <= '0;
            ct_q    <= '{default: '0};
            tag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            ghs_q   <= ghs_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            pt_q    <= pt_d;
            aad_q   <= aad_d;
            aes_q   <= aes_d;
            kwin_q  <= kwin_d;
            h_q     <= h_d;
            s_q     <= s_d;
            c_q     <= c_d;
            x_q     <= x_d;
            ct_q    <= ct_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

    assign ciphertext1 = ct_q[0];
    assign ciphertext2 = ct_q[1];
    assign ciphertext3 = ct_q[2];
    assign tag         = tag_q;
    assign done        = done_q;

endmodule

// File: tb/tb_aes256_gcm_top.sv
// Randomized bench for aes256_gcm_top against a table-driven AES-256 / GCM reference model.
module tb_aes256_gcm_top;

    localparam logic [255:0] K222  = 256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
    localparam logic [95:0]  N222  = 96'h12153524C0895E81B2C28465;
    localparam logic [223:0] A222  = 224'hD609B1F056637A0D46DF998D88E52E00B2C2846512153524C0895E81;
    localparam logic [127:0] P1    = 128'h08000F101112131415161718191A1B1C;
    localparam logic [127:0] P2    = 128'h1D1E1F202122232425262728292A2B2C;
    localparam logic [127:0] P3    = 128'h2D2E2F303132333435363738393A0002;
    localparam logic [127:0] C1    = 128'he2006eb42f5277022d9b19925bc419d7;
    localparam logic [127:0] C2    = 128'ha592666c925fe2ef718eb4e308efeaa7;
    localparam logic [127:0] C3    = 128'hc5273b394118860a5be2a97f56ab7836;
    localparam logic [127:0] T222  = 128'h5ca597cdbb3edb8d1a1151ea0af7b436;
    localparam logic [127:0] CZERO = 128'hcea7403d4d606b6e074ec5d3baf39d18;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [127:0] plaintext1, plaintext2, plaintext3;
    logic [223:0] aad;
    logic [127:0] ciphertext1, ciphertext2, ciphertext3, tag;
    logic         done;
`ifdef AES_GCM_DECRYPT_EN
    logic         decrypt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes256_gcm_top dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef AES_GCM_DECRYPT_EN
        .decrypt     (decrypt),
`endif
        .key         (key),
        .nonce       (nonce),
        .plaintext1  (plaintext1),
        .plaintext2  (plaintext2),
        .plaintext3  (plaintext3),
        .aad         (aad),
        .ciphertext1 (ciphertext1),
        .ciphertext2 (ciphertext2),
        .ciphertext3 (ciphertext3),
        .tag         (tag),
        .done        (done)
    );

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int j = 0; j < 16; j++) u[j] = sbox_t[s[j]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = u[r+4*((c+r)%4)];
            if (rd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rd + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
        return o;
    endfunction

    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    task automatic gcm_model(input logic [255:0] k, input logic [95:0] n,
                             input logic [127:0] p1, input logic [127:0] p2, input logic [127:0] p3,
                             input logic [223:0] a, input bit dec,
                             output logic [127:0] c1, output logic [127:0] c2,
                             output logic [127:0] c3, output logic [127:0] t);
        logic [127:0] h, s, x;
        logic [127:0] p [3];
        logic [127:0] c [3];
        logic [127:0] blk [6];
        h = aes_enc(k, 128'h0);
        s = aes_enc(k, {n, 32'd1});
        p[0] = p1; p[1] = p2; p[2] = p3;
        for (int i = 0; i < 3; i++) c[i] = p[i] ^ aes_enc(k, {n, 32'(i + 2)});
        blk[0] = a[223:96];
        blk[1] = {a[95:0], 32'h0};
        for (int i = 0; i < 3; i++) blk[2+i] = dec ? p[i] : c[i];
        blk[5] = {64'd224, 64'd384};
        x = '0;
        for (int i = 0; i < 6; i++) x = gf_mul(x ^ blk[i], h);
        c1 = c[0]; c2 = c[1]; c3 = c[2];
        t = x ^ s;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic scramble();
        key        = {rnd128(), rnd128()};
        nonce      = 96'(rnd128());
        plaintext1 = rnd128();
        plaintext2 = rnd128();
        plaintext3 = rnd128();
        aad        = 224'({rnd128(), rnd128()});
    endtask

    // mode 0: normal, 1: extra start pulse mid-run, 2: reset 40 cycles in
    task automatic do_run(input string nm, input logic [255:0] k, input logic [95:0] n,
                          input logic [127:0] p1, input logic [127:0] p2, input logic [127:0] p3,
                          input logic [223:0] a, input bit dec, input int mode);
        logic [127:0] e1, e2, e3, et;
        int lat;
        bit seen;
        gcm_model(k, n, p1, p2, p3, a, dec, e1, e2, e3, et);
        @(negedge clk);
        key = k; nonce = n; plaintext1 = p1; plaintext2 = p2; plaintext3 = p3; aad = a;
`ifdef AES_GCM_DECRYPT_EN
        decrypt = dec;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        check_eq({nm, "_done_clr"}, 128'(done), 128'h0);
        lat = 0;
        if (mode == 2) begin
            repeat (40) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            check_eq({nm, "_rst_done"}, 128'(done), 128'h0);
            check_eq({nm, "_rst_ct1"}, ciphertext1, 128'h0);
            check_eq({nm, "_rst_ct2"}, ciphertext2, 128'h0);
            check_eq({nm, "_rst_ct3"}, ciphertext3, 128'h0);
            check_eq({nm, "_rst_tag"}, tag, 128'h0);
            rst = 1'b0;
            seen = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check_eq({nm, "_no_done"}, 128'(seen), 128'h0);
        end else begin
            while (!done && lat < 200) begin
                if (mode == 1 && lat == 30) begin
                    start = 1'b1;
                    scramble();
                end
                if (mode == 1 && lat == 31) start = 1'b0;
                @(negedge clk);
                lat++;
            end
            check_eq({nm, "_latency"}, 128'(lat), 128'd82);
            check_eq({nm, "_ct1"}, ciphertext1, e1);
            check_eq({nm, "_ct2"}, ciphertext2, e2);
            check_eq({nm, "_ct3"}, ciphertext3, e3);
            check_eq({nm, "_tag"}, tag, et);
            $display("run %s: lat=%0d ct1=%h tag=%h", nm, lat, ciphertext1, tag);
        end
    endtask

    task automatic check_222(input string nm);
        check_eq({nm, "_k_ct1"}, ciphertext1, C1);
        check_eq({nm, "_k_ct2"}, ciphertext2, C2);
        check_eq({nm, "_k_ct3"}, ciphertext3, C3);
        check_eq({nm, "_k_tag"}, tag, T222);
    endtask

    initial begin
        bit stable;
        build_sbox();
        rst = 1'b1;
        start = 1'b0;
        key = '0; nonce = '0; plaintext1 = '0; plaintext2 = '0; plaintext3 = '0; aad = '0;
`ifdef AES_GCM_DECRYPT_EN
        decrypt = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_done", 128'(done), 128'h0);
        check_eq("reset_ct1", ciphertext1, 128'h0);
        check_eq("reset_tag", tag, 128'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_done", 128'(done), 128'h0);

        do_run("v222", K222, N222, P1, P2, P3, A222, 1'b0, 0);
        check_222("v222");

        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (done !== 1'b1 || ciphertext1 !== C1 || ciphertext2 !== C2 ||
                ciphertext3 !== C3 || tag !== T222) stable = 1'b0;
        end
        check_eq("hold_stable", 128'(stable), 128'h1);
        $display("hold: done=%0d after 100 idle cycles", done);

        do_run("second", K222, N222, P1, P2, P3, A222, 1'b0, 0);
        check_222("second");

        do_run("zero", 256'h0, 96'h0, 128'h0, 128'h0, 128'h0, 224'h0, 1'b0, 0);
        check_eq("zero_k_ct1", ciphertext1, CZERO);

        do_run("abort", K222, N222, P1, P2, P3, A222, 1'b0, 2);
        do_run("fresh", K222, N222, P1, P2, P3, A222, 1'b0, 0);
        check_222("fresh");

        do_run("repulse", K222, N222, P1, P2, P3, A222, 1'b0, 1);
        check_222("repulse");

        for (int i = 0; i < 6; i++) begin
            bit d;
            logic [255:0] k;
            logic [223:0] a;
            logic [127:0] p1, p2, p3;
            logic [95:0]  n;
            k  = {rnd128(), rnd128()};
            a  = 224'({rnd128(), rnd128()});
            n  = 96'(rnd128());
            p1 = rnd128(); p2 = rnd128(); p3 = rnd128();
`ifdef AES_GCM_DECRYPT_EN
            d = 1'($urandom_range(0, 1));
`else
            d = 1'b0;
`endif
            do_run($sformatf("rand%0d", i), k, n, p1, p2, p3, a, d, 0);
        end

`ifdef AES_GCM_DECRYPT_EN
        do_run("dec222", K222, N222, C1, C2, C3, A222, 1'b1, 0);
        check_eq("dec222_k_pt1", ciphertext1, P1);
        check_eq("dec222_k_pt2", ciphertext2, P2);
        check_eq("dec222_k_pt3", ciphertext3, P3);
        check_eq("dec222_k_tag", tag, T222);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
